// File: rtl/apb_master_exe_w47_if.sv
// rtl/apb_master_exe_w47_if.sv - command/response and APB bus bundle for apb_master_exe_w47
interface apb_master_exe_w47_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_write;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [DATA_WIDTH-1:0] i_cmd_wdata;
  logic                  o_rsp_valid;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;
  logic [ADDR_WIDTH-1:0] o_PADDR;
  logic                  o_PSEL;
  logic                  o_PENABLE;
  logic                  o_PWRITE;
  logic [DATA_WIDTH-1:0] o_PWDATA;
  logic                  i_PREADY;
  logic [DATA_WIDTH-1:0] i_PRDATA;
  logic                  i_PSLVERR;

  // Requester view: takes commands, drives APB request, reports responses
  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA,
    input  i_PREADY, i_PRDATA, i_PSLVERR
  );

  // Environment view: command source plus APB completer
  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA,
    output i_PREADY, i_PRDATA, i_PSLVERR
  );
endinterface

// File: rtl/apb_master_exe_w47.sv
// rtl/apb_master_exe_w47.sv - single-command APB requester, optional access timeout via APB_MASTER_TIMEOUT_EN
module apb_master_exe_w47 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  apb_master_exe_w47_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  // Abort fires on the wait state that would bring the count to the limit
  assign tmo_hit = ((tmo_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid && cmd_ready_q) begin
          pwrite_d = bus.i_cmd_write;
          paddr_d  = bus.i_cmd_addr;
          pwdata_d = bus.i_cmd_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (bus.i_PREADY) begin
          // Completion outranks a timeout landing on the same edge
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.i_PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : bus.i_PRDATA;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          if (tmo_hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            psel_d    = 1'b1;
            penable_d = 1'b1;
          end
`else
          psel_d    = 1'b1;
          penable_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Wait-state counter for the access timeout
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign bus.o_cmd_ready = cmd_ready_q;
  assign bus.o_PSEL      = psel_q;
  assign bus.o_PENABLE   = penable_q;
  assign bus.o_PWRITE    = pwrite_q;
  assign bus.o_PADDR     = paddr_q;
  assign bus.o_PWDATA    = pwdata_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_exe_w47.sv
// tb/tb_apb_master_exe_w47.sv - directed and randomized check of apb_master_exe_w47 against a transaction-level model
module tb_apb_master_exe_w47;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  apb_master_exe_w47_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  apb_master_exe_w47 #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(16),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .i_PCLK   (clk),
    .i_PRESET (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with the model value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer: the model says the response appears 3+waits cycles after
  // the accept edge, carries the final-beat error, and read data only for reads
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                      input int waits, input logic err, input logic [7:0] rd);
    int rsp_cyc;
    int acc_cnt;
    chk("ready_before_cmd", 32'(bus.o_cmd_ready), 32'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = wr;
    bus.i_cmd_addr  = a;
    bus.i_cmd_wdata = wd;
    bus.i_PREADY    = 1'b0;
    @(posedge clk); #1;
    chk("setup_psel", 32'(bus.o_PSEL), 32'd1);
    chk("setup_penable", 32'(bus.o_PENABLE), 32'd0);
    chk("setup_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("setup_paddr", 32'(bus.o_PADDR), 32'(a));
    chk("setup_pwrite", 32'(bus.o_PWRITE), 32'(wr));
    chk("setup_pwdata", 32'(bus.o_PWDATA), 32'(wd));
    rsp_cyc = -1;
    acc_cnt = 0;
    for (int k = 1; k <= waits + 10; k++) begin
      // Busy-time command traffic must be ignored
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_write = 1'($urandom);
      bus.i_cmd_addr  = 16'($urandom);
      bus.i_cmd_wdata = 8'($urandom);
      if (bus.o_PENABLE) begin
        if (acc_cnt == waits) begin
          bus.i_PREADY  = 1'b1;
          bus.i_PSLVERR = err;
          bus.i_PRDATA  = rd;
        end else begin
          bus.i_PREADY  = 1'b0;
          bus.i_PSLVERR = 1'b1;
          bus.i_PRDATA  = 8'($urandom);
        end
        acc_cnt++;
      end else begin
        bus.i_PREADY = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.o_rsp_valid) begin
        rsp_cyc = k + 1;
        break;
      end
      chk("access_psel", 32'(bus.o_PSEL), 32'd1);
      chk("access_penable", 32'(bus.o_PENABLE), 32'd1);
      chk("access_paddr_stable", 32'(bus.o_PADDR), 32'(a));
      chk("access_pwdata_stable", 32'(bus.o_PWDATA), 32'(wd));
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_PREADY    = 1'b0;
    bus.i_PSLVERR   = 1'b0;
    chk("rsp_latency", 32'(rsp_cyc), 32'(3 + waits));
    chk("rsp_rdata", 32'(bus.o_rsp_rdata), wr ? 32'd0 : 32'(rd));
    chk("rsp_err", 32'(bus.o_rsp_err), 32'(err));
    chk("rsp_psel_low", 32'(bus.o_PSEL), 32'd0);
    chk("rsp_penable_low", 32'(bus.o_PENABLE), 32'd0);
    chk("rsp_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("rsp_paddr_hold", 32'(bus.o_PADDR), 32'(a));
    @(posedge clk); #1;
    chk("rsp_one_cycle", 32'(bus.o_rsp_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s[3];
    int n_setup;
    int n_rsp;
    int tmo_k;
    logic [7:0] rd_b2b;
    logic [7:0] rd_last;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_wdata = '0;
    bus.i_PREADY    = 1'b0;
    bus.i_PRDATA    = '0;
    bus.i_PSLVERR   = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("rst_psel", 32'(bus.o_PSEL), 32'd0);
    chk("rst_penable", 32'(bus.o_PENABLE), 32'd0);
    chk("rst_paddr", 32'(bus.o_PADDR), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(bus.o_cmd_ready), 32'd1);

    // Directed: zero-wait write, three-wait read, error beat with ignored early error
    xfer(1'b1, 16'h0001, 8'h5A, 0, 1'b0, 8'hEE);
    xfer(1'b0, 16'h0000, 8'h00, 3, 1'b0, 8'hC3);
    xfer(1'b0, 16'h0002, 8'h00, 2, 1'b1, 8'h77);
    xfer(1'b0, 16'h0003, 8'h00, 2, 1'b0, 8'h11);

    // Randomized transfers
    for (int i = 0; i < 10; i++) begin
      xfer(1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
           1'($urandom), 8'($urandom));
    end

    // Back-to-back with command valid held: setups three cycles apart
    rd_b2b = 8'($urandom);
    rd_last = 8'h00;
    n_setup = 0;
    n_rsp = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_addr  = 16'h0010;
    bus.i_cmd_wdata = 8'h21;
    for (int k = 1; k <= 40; k++) begin
      bus.i_PREADY = 1'b1;
      bus.i_PRDATA = rd_b2b;
      @(posedge clk); #1;
      if (bus.o_PSEL && !bus.o_PENABLE && n_setup < 3) begin
        s[n_setup] = k;
        n_setup++;
        if (n_setup == 1) begin
          bus.i_cmd_addr  = 16'h0011;
          bus.i_cmd_wdata = 8'h42;
        end else if (n_setup == 2) begin
          bus.i_cmd_write = 1'b0;
          bus.i_cmd_addr  = 16'h0000;
        end else begin
          bus.i_cmd_valid = 1'b0;
        end
      end
      if (bus.o_rsp_valid) begin
        n_rsp++;
        rd_last = bus.o_rsp_rdata;
        if (n_rsp == 3) break;
      end
    end
    bus.i_PREADY = 1'b0;
    bus.i_cmd_valid = 1'b0;
    chk("b2b_setups", 32'(n_setup), 32'd3);
    chk("b2b_responses", 32'(n_rsp), 32'd3);
    chk("b2b_gap_1", 32'(s[1] - s[0]), 32'd3);
    chk("b2b_gap_2", 32'(s[2] - s[1]), 32'd3);
    chk("b2b_read_data", 32'(rd_last), 32'(rd_b2b));
    @(posedge clk); #1;

    // Reset in the middle of an access
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr  = 16'h0005;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_penable", 32'(bus.o_PENABLE), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_psel", 32'(bus.o_PSEL), 32'd0);
    chk("async_rst_penable", 32'(bus.o_PENABLE), 32'd0);
    chk("async_rst_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("async_rst_rsp", 32'(bus.o_rsp_valid), 32'd0);
    @(posedge clk); #1;
    bus.i_PREADY = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("post_rst_rsp", 32'(bus.o_rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_rsp_2", 32'(bus.o_rsp_valid), 32'd0);
    bus.i_PREADY = 1'b0;

    // Completer never ready
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr  = 16'h0007;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    bus.i_PRDATA = 8'hAB;
    tmo_k = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.o_rsp_valid) begin
        tmo_k = k;
        break;
      end
    end
`ifdef APB_MASTER_TIMEOUT_EN
    chk("tmo_access_cycles", 32'(tmo_k - 1), 32'd15);
    chk("tmo_err", 32'(bus.o_rsp_err), 32'd1);
    chk("tmo_rdata", 32'(bus.o_rsp_rdata), 32'd0);
    chk("tmo_ready", 32'(bus.o_cmd_ready), 32'd1);
`else
    chk("hang_no_rsp", 32'(tmo_k), 32'hFFFF_FFFF);
    chk("hang_psel", 32'(bus.o_PSEL), 32'd1);
    chk("hang_penable", 32'(bus.o_PENABLE), 32'd1);
    chk("hang_paddr", 32'(bus.o_PADDR), 32'h0007);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 16'h0009, 8'h00, 1, 1'b0, 8'h5C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_exe_w47.md
APB_MASTER_EXE_W47 -- requirements
Module: apb_master_exe_w47

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of PWDATA, PRDATA, command write data and response read data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the width of PADDR and the command address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum ACCESS cycles with PREADY low before abort (used only with the REQ-030 macro).
REQ-004 SHALL use one clock and an asynchronous, active-high reset; clock and reset are fixed as below.
REQ-005 i_PCLK  input  1  APB clock; all state changes on the rising edge.
REQ-006 i_PRESET  input  1  asynchronous active-high reset.
REQ-007 i_cmd_valid  input  1  command request.
REQ-008 o_cmd_ready  output  1  command accepted when high together with i_cmd_valid.
REQ-009 i_cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-010 i_cmd_addr  input  ADDR_WIDTH  target register address.
REQ-011 i_cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 o_rsp_valid  output  1  one-cycle completion pulse.
REQ-013 o_rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and aborts.
REQ-014 o_rsp_err  output  1  slave error or timeout.
REQ-015 o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA  outputs  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB requester signals to the exe-unit slave.
REQ-016 i_PREADY, i_PRDATA, i_PSLVERR  inputs  1/DATA_WIDTH/1  APB completer signals.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-018 IDLE: o_cmd_ready=1, o_PSEL=0, o_PENABLE=0; on i_cmd_valid&o_cmd_ready SHALL latch write/addr/wdata into o_PWRITE/o_PADDR/o_PWDATA and go to SETUP.
REQ-019 SETUP (exactly one cycle): o_PSEL=1, o_PENABLE=0, o_cmd_ready=0; go to ACCESS unconditionally.
REQ-020 ACCESS: o_PSEL=1, o_PENABLE=1; i_PREADY sampled each edge; stay while i_PREADY=0 (wait states unbounded unless REQ-030 applies).
REQ-021 ACCESS with i_PREADY=1: next cycle o_rsp_valid=1 for exactly one cycle, o_rsp_err=i_PSLVERR, o_rsp_rdata=i_PRDATA for reads else 0; o_PSEL=o_PENABLE=0; state IDLE.
REQ-022 i_PSLVERR and i_PRDATA SHALL be ignored except when i_PREADY=1 in ACCESS.
REQ-023 o_PADDR, o_PWRITE and o_PWDATA SHALL stay stable from SETUP through transfer end, and hold their last value in IDLE.
REQ-024 Minimum latency: accept edge N, SETUP cycle N+1, ACCESS cycle N+2, o_rsp_valid cycle N+3 with zero wait states; each wait state adds one cycle.
REQ-025 Back-to-back: o_cmd_ready SHALL reassert in the same cycle as o_rsp_valid, so the next command reaches SETUP at N+4 at the earliest.
REQ-026 i_cmd_* SHALL be ignored outside IDLE; there is no command queue.

Reset
REQ-027 i_PRESET=1 SHALL asynchronously force state IDLE, o_cmd_ready=0, and all other outputs to 0.
REQ-028 On the first edge after i_PRESET deasserts: o_cmd_ready=1.
REQ-029 Reset mid-transfer SHALL drop the transfer with no o_rsp_valid, and PSEL/PENABLE SHALL fall immediately.

Configuration
REQ-030 With APB_MASTER_TIMEOUT_EN defined: a counter SHALL clear on ACCESS entry and increment on each ACCESS cycle with i_PREADY=0; at TIMEOUT_CYCLES the transfer aborts: o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata=0, return to IDLE.
REQ-031 If i_PREADY=1 on the same edge as the count reaches TIMEOUT_CYCLES, normal completion SHALL win.
REQ-032 Without APB_MASTER_TIMEOUT_EN: no counter logic, and ACCESS waits indefinitely.

Verification
REQ-033 Write addr=1, wdata=0x5A, PREADY high on first ACCESS -> PSEL cycle N+1, PENABLE cycle N+2, rsp_valid N+3, rdata=0, err=0.
REQ-034 Read addr=0, PREADY after 3 wait states, PRDATA=0xC3 -> rsp_valid at N+6, rdata=0xC3, PADDR stable throughout.
REQ-035 Read with PSLVERR=1 with PREADY=1 -> rsp_err=1, and a PSLVERR pulse while PREADY=0 is ignored.
REQ-036 i_PRESET asserted during ACCESS -> PSEL/PENABLE 0 without waiting for an edge, no rsp_valid, o_cmd_ready=1 one edge after release.
REQ-037 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=15, PREADY held low -> rsp_valid with err=1, rdata=0, after 15 ACCESS cycles; without the macro, still in ACCESS at cycle 100.
REQ-038 Three back-to-back commands (write oper, write argA, read addr 0) with cmd_valid held -> consecutive SETUPs exactly 3 cycles apart.
